// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter and boot sequencer: the loader fills memory in LOAD,
// then the CPU fetch unit shares the single port with the loader in RUN.
module imem_arbiter #(
    parameter int DEPTH        = 256,
    parameter int AW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_err,
    input  logic          load_req,
    input  logic [31:0]   load_addr,
    input  logic [31:0]   load_wdata,
    output logic          load_gnt,
    output logic          load_err,
    input  logic          load_done,
    output logic          cpu_run,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t     state;
    logic [2:0] starve_cnt;
    logic       fetch_ok;
    logic       load_ok;
    logic       rvld_p1;
    logic       rerr_p1;
    logic       lerr_p1;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [2:0] starve_sat_inc(input logic [2:0] c);
        return (c >= 3'(STARVE_LIMIT)) ? 3'(STARVE_LIMIT) : c + 3'd1;
    endfunction

    // Stage p0: grant decision and memory port drive, all combinational
    always_comb begin
        fetch_ok  = addr_legal(fetch_addr);
        load_ok   = addr_legal(load_addr);
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (state == ST_LOAD) begin
                load_gnt = load_req;
            end else begin
                fetch_gnt = fetch_req && (!load_req || (starve_cnt >= 3'(STARVE_LIMIT)));
                load_gnt  = load_req && !fetch_gnt;
            end
        end
        mem_we    = load_gnt && load_ok;
        mem_en    = mem_we || (fetch_gnt && fetch_ok);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we) begin
            mem_addr  = load_addr[AW+1:2];
            mem_wdata = load_wdata;
        end else if (mem_en) begin
            mem_addr = fetch_addr[AW+1:2];
        end
    end

    // Stage p1: phase FSM, starvation counter and response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            cpu_run    <= 1'b0;
            starve_cnt <= 3'd0;
            rvld_p1    <= 1'b0;
            rerr_p1    <= 1'b0;
            lerr_p1    <= 1'b0;
        end else begin
            if (state == ST_LOAD && load_done) begin
                state   <= ST_RUN;
                cpu_run <= 1'b1;
            end
            rvld_p1 <= fetch_gnt;
            rerr_p1 <= fetch_gnt && !fetch_ok;
            lerr_p1 <= load_gnt && !load_ok;
            if (fetch_gnt || !fetch_req) begin
                starve_cnt <= 3'd0;
            end else if (load_gnt) begin
                starve_cnt <= starve_sat_inc(starve_cnt);
            end
        end
    end

    // A response still in flight when reset arrives is suppressed.
    assign fetch_rvalid = rvld_p1 && !rst;
    assign fetch_err    = rerr_p1 && !rst;
    assign fetch_rdata  = (fetch_rvalid && !fetch_err) ? mem_rdata : 32'd0;
    assign load_err     = lerr_p1;

endmodule
